// File: rtl/swap_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : swap_pipe_if
// Brief    : Producer/consumer handshake bundle for swap_pipe.
// Revision : 1.0
// ============================================================================
interface swap_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             in_swap;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;

  modport master (
    output in_valid, in_swap, a, b, out_ready,
    input  in_ready, out_valid, out1, out2
  );

  modport slave (
    input  in_valid, in_swap, a, b, out_ready,
    output in_ready, out_valid, out1, out2
  );
endinterface
`default_nettype wire

// File: rtl/swap_pipe.sv
`default_nettype none
// ============================================================================
// Module   : swap_pipe
// Brief    : Elastic DEPTH-stage operand pipeline with per-item output swap.
// Revision : 1.0
// ============================================================================
module swap_pipe #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 7,
  parameter int SWAP_EN = 1
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        flush,
  swap_pipe_if.slave                       bus,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int             c_cnt_w   = $clog2(DEPTH+1);
  localparam logic           c_swap_en = (SWAP_EN != 0);
  localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_swap;
  logic [WIDTH-1:0]   r_a [DEPTH];
  logic [WIDTH-1:0]   r_b [DEPTH];
  logic [c_cnt_w-1:0] r_count;

  logic [DEPTH-1:0]   w_go;
  logic               w_hole;
  logic               w_accept;
  logic               w_deliver;

  // A stage may take new content when the consumer drains or any stage at or
  // beyond it is empty; this lets bubbles collapse without a ripple chain.
  always_comb begin
    w_hole = 1'b0;
    w_go   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_hole  = w_hole | ~r_valid[i];
      w_go[i] = bus.out_ready | w_hole;
    end
  end

  assign bus.in_ready = w_go[0];
  assign w_accept     = bus.in_valid & w_go[0];
  assign w_deliver    = r_valid[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_swap  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      if (w_go[0]) begin
        r_valid[0] <= bus.in_valid;
        r_swap[0]  <= bus.in_swap & c_swap_en;
        r_a[0]     <= bus.a;
        r_b[0]     <= bus.b;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_go[i]) begin
          r_valid[i] <= r_valid[i-1];
          r_swap[i]  <= r_swap[i-1];
          r_a[i]     <= r_a[i-1];
          r_b[i]     <= r_b[i-1];
        end
      end
      // Flush overrides every load above, including a same-cycle accept.
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept && !w_deliver) begin
      r_count <= r_count + c_one;
    end else if (!w_accept && w_deliver) begin
      r_count <= r_count - c_one;
    end
  end

  assign count         = r_count;
  assign bus.out_valid = r_valid[DEPTH-1];
  assign bus.out1      = r_swap[DEPTH-1] ? r_b[DEPTH-1] : r_a[DEPTH-1];
  assign bus.out2      = r_swap[DEPTH-1] ? r_a[DEPTH-1] : r_b[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_swap_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_swap_pipe
// Brief    : Randomized and directed check of three swap_pipe variants.
// Revision : 1.0
// ============================================================================
module tb_swap_pipe;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_swap, s_oready, s_flush;
  logic [63:0] s_a, s_b;

  swap_pipe_if #(.WIDTH(64)) bus0 ();
  swap_pipe_if #(.WIDTH(64)) bus1 ();
  swap_pipe_if #(.WIDTH(8))  bus2 ();
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [0:0] cnt2;

  assign bus0.in_valid = s_valid;  assign bus0.in_swap = s_swap;
  assign bus0.a = s_a;             assign bus0.b = s_b;
  assign bus0.out_ready = s_oready;
  assign bus1.in_valid = s_valid;  assign bus1.in_swap = s_swap;
  assign bus1.a = s_a;             assign bus1.b = s_b;
  assign bus1.out_ready = s_oready;
  assign bus2.in_valid = s_valid;  assign bus2.in_swap = s_swap;
  assign bus2.a = s_a[7:0];        assign bus2.b = s_b[7:0];
  assign bus2.out_ready = s_oready;

  swap_pipe #(.WIDTH(64), .DEPTH(7), .SWAP_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(s_flush), .bus(bus0), .count(cnt0));
  swap_pipe #(.WIDTH(64), .DEPTH(7), .SWAP_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(s_flush), .bus(bus1), .count(cnt1));
  swap_pipe #(.WIDTH(8), .DEPTH(1), .SWAP_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(s_flush), .bus(bus2), .count(cnt2));

  always #5 clk = ~clk;

  // Reference: each variant is an ordered list of items tagged with the stage
  // they currently occupy.
  int          dep  [NI];
  logic        swen [NI];
  logic [63:0] msk  [NI];
  int          m_n  [NI];
  int          m_pos[NI][8];
  logic [63:0] m_a  [NI][8];
  logic [63:0] m_b  [NI][8];
  logic        m_sw [NI][8];

  logic [63:0] o_rdy[NI], o_ov[NI], o_cnt[NI], o_1[NI], o_2[NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample();
    o_rdy[0] = 64'(bus0.in_ready); o_ov[0] = 64'(bus0.out_valid); o_cnt[0] = 64'(cnt0);
    o_1[0]   = 64'(bus0.out1);     o_2[0]  = 64'(bus0.out2);
    o_rdy[1] = 64'(bus1.in_ready); o_ov[1] = 64'(bus1.out_valid); o_cnt[1] = 64'(cnt1);
    o_1[1]   = 64'(bus1.out1);     o_2[1]  = 64'(bus1.out2);
    o_rdy[2] = 64'(bus2.in_ready); o_ov[2] = 64'(bus2.out_valid); o_cnt[2] = 64'(cnt2);
    o_1[2]   = 64'(bus2.out1);     o_2[2]  = 64'(bus2.out2);
  endtask

  task automatic model_step(input int k);
    int          d, n;
    logic        er, eov, hole;
    logic [63:0] e1, e2;
    bit          occ[8];
    d   = dep[k];
    n   = m_n[k];
    er  = s_oready || (n < d);
    eov = (n > 0) && (m_pos[k][0] == d - 1);
    check($sformatf("in_ready[%0d]", k), o_rdy[k], 64'(er));
    check($sformatf("out_valid[%0d]", k), o_ov[k], 64'(eov));
    check($sformatf("count[%0d]", k), o_cnt[k], 64'(n));
    if (eov) begin
      e1 = (m_sw[k][0] && swen[k]) ? m_b[k][0] : m_a[k][0];
      e2 = (m_sw[k][0] && swen[k]) ? m_a[k][0] : m_b[k][0];
      check($sformatf("out1[%0d]", k), o_1[k], e1);
      check($sformatf("out2[%0d]", k), o_2[k], e2);
    end
    for (int j = 0; j < 8; j++) occ[j] = 1'b0;
    for (int i = 0; i < n; i++) occ[m_pos[k][i]] = 1'b1;
    if (s_flush) begin
      n = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (m_pos[k][i] < d - 1) begin
          hole = 1'b0;
          for (int j = m_pos[k][i] + 1; j < d; j++) if (!occ[j]) hole = 1'b1;
          if (s_oready || hole) m_pos[k][i]++;
        end
      end
      if (eov && s_oready) begin
        for (int i = 1; i < n; i++) begin
          m_pos[k][i-1] = m_pos[k][i];
          m_a[k][i-1]   = m_a[k][i];
          m_b[k][i-1]   = m_b[k][i];
          m_sw[k][i-1]  = m_sw[k][i];
        end
        n--;
      end
      if (s_valid && er) begin
        m_pos[k][n] = 0;
        m_a[k][n]   = s_a & msk[k];
        m_b[k][n]   = s_b & msk[k];
        m_sw[k][n]  = s_swap;
        n++;
      end
    end
    m_n[k] = n;
  endtask

  // Called at posedge+1 with inputs already driven; checks, models the edge.
  task automatic step();
    #1;
    sample();
    for (int k = 0; k < NI; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0; s_flush = 1'b0; s_oready = 1'b1;
    repeat (10) step();
  endtask

  int idx;
  int ndel;

  initial begin
    dep[0] = 7; swen[0] = 1'b1; msk[0] = '1;
    dep[1] = 7; swen[1] = 1'b0; msk[1] = '1;
    dep[2] = 1; swen[2] = 1'b1; msk[2] = 64'hFF;
    for (int k = 0; k < NI; k++) m_n[k] = 0;
    rst = 1'b1; s_valid = 1'b0; s_swap = 1'b0; s_oready = 1'b0; s_flush = 1'b0;
    s_a = '0; s_b = '0;

    #2;
    check("rst_ov0",  64'(bus0.out_valid), 64'd0);
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_out10", bus0.out1, 64'd0);
    check("rst_out22", 64'(bus2.out2), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single item, no swap, then with swap
    for (int sw = 0; sw < 2; sw++) begin
      s_oready = 1'b1; s_valid = 1'b1; s_swap = sw[0];
      s_a = 64'h1111111111111111; s_b = 64'h2222222222222222;
      step();
      s_valid = 1'b0;
      repeat (6) step();
      step();
      check($sformatf("lat_ov_sw%0d", sw), o_ov[0], 64'd1);
      check($sformatf("lat_out1_sw%0d", sw), o_1[0], sw ? 64'h2222222222222222 : 64'h1111111111111111);
      check($sformatf("noswap_out1_sw%0d", sw), o_1[1], 64'h1111111111111111);
      drain();
    end

    // Backpressure: stream 10 items into a stalled pipe, then release
    s_oready = 1'b0; s_swap = 1'b0; idx = 0;
    repeat (10) begin
      s_valid = 1'b1; s_a = 64'(idx); s_b = 64'(idx + 100);
      step();
      if (o_rdy[0][0]) idx++;
    end
    check("bp_cnt_sat", o_cnt[0], 64'd7);
    check("bp_in_ready", o_rdy[0], 64'd0);
    s_oready = 1'b1; ndel = 0;
    for (int t = 0; t < 10; t++) begin
      s_valid = (idx < 10); s_a = 64'(idx); s_b = 64'(idx + 100);
      step();
      if (o_rdy[0][0] && s_valid) idx++;
      check($sformatf("bp_gapless%0d", t), o_ov[0], 64'd1);
      check($sformatf("bp_order%0d", t), o_1[0], 64'(t));
    end
    drain();

    // Bubble collapse: three items two cycles apart into a stalled pipe
    s_oready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      s_valid = (t % 2 == 0); s_a = 64'(t + 40); s_b = 64'(t + 80);
      step();
    end
    s_valid = 1'b0;
    repeat (8) step();
    check("bub_cnt", o_cnt[0], 64'd3);
    s_oready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      check($sformatf("bub_packed%0d", t), o_ov[0], 64'd1);
    end
    drain();

    // Flush with five items in flight and an item offered during flush
    s_oready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      s_valid = 1'b1; s_a = 64'(t + 200); s_b = 64'(t + 300);
      step();
    end
    s_flush = 1'b1; s_a = 64'hDEAD; step();
    s_flush = 1'b0; s_valid = 1'b0;
    step();
    check("flush_cnt", o_cnt[0], 64'd0);
    check("flush_ov", o_ov[0], 64'd0);
    s_oready = 1'b1; ndel = 0;
    repeat (10) begin
      step();
      if (o_ov[0][0]) ndel++;
    end
    check("flush_nodeliver", 64'(ndel), 64'd0);

    // Asynchronous reset mid-cycle with four items in flight
    s_oready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      s_valid = 1'b1; s_a = 64'(t + 9); s_b = 64'(t + 19);
      step();
    end
    s_valid = 1'b0;
    repeat (7) step();
    check("ar_pre_cnt", o_cnt[0], 64'd4);
    #3;
    rst = 1'b1;
    #1;
    check("ar_ov", 64'(bus0.out_valid), 64'd0);
    check("ar_cnt", 64'(cnt0), 64'd0);
    check("ar_out1", bus0.out1, 64'd0);
    check("ar_out2", bus0.out2, 64'd0);
    check("ar_ov2", 64'(bus2.out_valid), 64'd0);
    for (int k = 0; k < NI; k++) m_n[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Random traffic
    repeat (600) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      s_oready = ($urandom_range(0, 2) != 0);
      s_swap   = 1'($urandom);
      s_a      = {$urandom, $urandom};
      s_b      = {$urandom, $urandom};
      s_flush  = ($urandom_range(0, 49) == 0);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/swap_pipe.md
SWAP_PIPE -- requirements
Module: swap_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; legal range 1..128.
REQ-002 Parameter DEPTH, default 7, number of pipeline stages; legal range 1..32.
REQ-003 Parameter SWAP_EN, default 1: 1 = per-item swap honoured; 0 = in_swap ignored, always pass-through.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all in-flight items.
REQ-007 in_valid  input  1  producer presents an item.
REQ-008 in_ready  output  1  pipeline can accept an item this cycle.
REQ-009 in_swap  input  1  item's swap request.
REQ-010 a  input  WIDTH  first operand.
REQ-011 b  input  WIDTH  second operand.
REQ-012 out_valid  output  1  stage DEPTH-1 holds a valid item.
REQ-013 out_ready  input  1  consumer accepts the output item.
REQ-014 out1  output  WIDTH  first result.
REQ-015 out2  output  WIDTH  second result.
REQ-016 count  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-017 Each stage SHALL hold a valid bit, a swap bit, and two WIDTH-bit data registers; outputs SHALL be driven directly from stage DEPTH-1 registers (no combinational data path from inputs to outputs).
REQ-018 Handshake: an item is accepted on a rising edge where in_valid && in_ready; it is delivered on a rising edge where out_valid && out_ready.
REQ-019 Stage i (i < DEPTH-1) SHALL advance into stage i+1 when stage i+1 is empty or stage i+1 itself advances; stage DEPTH-1 advances when out_ready is high.
REQ-020 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances); a combinational path from out_ready to in_ready is permitted.
REQ-021 Bubbles SHALL collapse: an empty stage accepts from its predecessor even while downstream stalls.
REQ-022 Latency with no backpressure SHALL be DEPTH edges: an item accepted on edge k is presented with out_valid=1 after edge k+DEPTH-1 and delivered at edge k+DEPTH-1+n with out_ready high.
REQ-023 Full throughput: one item per cycle sustained while in_valid and out_ready are both high.
REQ-024 While out_valid && !out_ready, out1, out2, and out_valid SHALL hold stable.
REQ-025 Swap: with SWAP_EN=1 and the item's swap bit set, out1 = item b and out2 = item a; otherwise out1 = a and out2 = b. Swap is applied at output select; data registers carry a and b unmodified.
REQ-026 Item order SHALL be preserved; no item is dropped or duplicated except by flush or reset.
REQ-027 count SHALL equal the number of set stage valid bits, updated each edge: +1 on accept, -1 on deliver, unchanged on simultaneous accept and deliver.
REQ-028 Full (count==DEPTH) with out_ready low: in_ready=0; full with out_ready high: in_ready=1, simultaneous accept and deliver.
REQ-029 flush high on an edge SHALL clear all valid bits (count=0 next cycle); flush beats a same-cycle accept; the input item is dropped and its delivery does not count.
REQ-030 in_ready MAY be 1 during flush; items offered during flush are discarded.
REQ-031 Data registers of empty stages are don't-care; out1/out2 SHALL be ignored while out_valid=0.
REQ-032 DEPTH=1 SHALL work: single stage, in_ready = !out_valid || out_ready.

Reset
REQ-033 rst high SHALL immediately (asynchronously) clear all valid and swap bits and zero all data registers: out_valid=0, out1=out2=0, count=0.
REQ-034 in_ready SHALL be 1 one cycle after rst deasserts; rst asserted mid-operation discards all in-flight items.

Verification
REQ-035 Defaults: with out_ready=1, accept a=0x1111111111111111, b=0x2222222222222222, swap=0 at edge 0 -> out_valid rises after edge 6 with out1=0x1111..., out2=0x2222...
REQ-036 Swap: same item with in_swap=1 -> out1=0x2222..., out2=0x1111...; repeat with SWAP_EN=0 -> no swap.
REQ-037 Backpressure: stream 10 incrementing items with out_ready=0 -> count saturates at 7 and in_ready=0; then raise out_ready -> items 0..9 delivered in order, one per cycle, without gaps.
REQ-038 Bubble collapse: enqueue 3 items spaced 2 cycles apart with out_ready=0 -> count=3 and all items packed into stages 4..6.
REQ-039 Flush: with 5 items in flight, assert flush for 1 cycle with in_valid=1 -> count=0 and out_valid=0 on the next cycle; the item offered during flush is never delivered.
REQ-040 Async reset: assert rst between clock edges with count=4 -> out_valid, count, and out1/out2 go to 0 before the next edge; DEPTH=1 and WIDTH=8 variants pass REQ-035 and REQ-037 equivalents.
